// File: rtl/tilemap_video_engine_pkg.sv
// tilemap_video_engine_pkg: region codes, register map, CTRL fields and address-width helpers
package tilemap_video_engine_pkg;
  localparam int TILE_LOG2_DEF = 4;
  localparam int SCALE_LOG2_DEF = 1;
  localparam int MAP_COLS_LOG2_DEF = 6;
  localparam int MAP_ROWS_LOG2_DEF = 6;
  localparam int TILE_IDX_W_DEF = 6;
  localparam int COLOR_W_DEF = 3;
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_BG_LSB = 4;
  typedef enum logic [3:0] {RGN_REG = 4'd0, RGN_TEX = 4'd1, RGN_TILE = 4'd2} region_e;
  typedef enum logic [1:0] {REG_CTRL, REG_SCROLL_X, REG_SCROLL_Y, REG_STATUS} reg_e;
  function automatic int tile_aw(input int cols_log2, input int rows_log2);
    return cols_log2 + rows_log2;
  endfunction
  function automatic int tex_aw(input int idx_w, input int tile_log2, input int scale_log2);
    return idx_w + 2 * (tile_log2 - scale_log2);
  endfunction
endpackage

// File: rtl/tilemap_video_engine_if.sv
// tilemap_video_engine_if: iomem bus between the SoC decoder (master) and the engine (slave)
interface tilemap_video_engine_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  modport master(output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, input iomem_ready, iomem_rdata);
  modport slave(input iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, output iomem_ready, iomem_rdata);
endinterface

// File: rtl/tilemap_dp_ram.sv
// tilemap_dp_ram: one write port, one registered read port with enable; old data on same-address collision
module tilemap_dp_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/tilemap_video_engine.sv
// tilemap_video_engine: scrolled tile-map pixel pipeline with iomem register/RAM access
module tilemap_video_engine
  import tilemap_video_engine_pkg::*;
#(
  parameter int TILE_LOG2     = TILE_LOG2_DEF,
  parameter int SCALE_LOG2    = SCALE_LOG2_DEF,
  parameter int MAP_COLS_LOG2 = MAP_COLS_LOG2_DEF,
  parameter int MAP_ROWS_LOG2 = MAP_ROWS_LOG2_DEF,
  parameter int TILE_IDX_W    = TILE_IDX_W_DEF,
  parameter int COLOR_W       = COLOR_W_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  tilemap_video_engine_if.slave  bus,
  input  logic                   pix_en,
  input  logic [9:0]             x_px,
  input  logic [9:0]             y_px,
  input  logic                   active_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic [COLOR_W-1:0]     vga_rgb
);
  localparam int SX_W = MAP_COLS_LOG2 + TILE_LOG2;
  localparam int SY_W = MAP_ROWS_LOG2 + TILE_LOG2;
  localparam int TE = TILE_LOG2 - SCALE_LOG2;
  localparam int TILE_AW = tile_aw(MAP_COLS_LOG2, MAP_ROWS_LOG2);
  localparam int TEX_AW = tex_aw(TILE_IDX_W, TILE_LOG2, SCALE_LOG2);
  logic ready_q, en_q, vblank_q;
  logic [31:0] rdata_q, rdata_d, reg_rd, ctrl_rd;
  logic [COLOR_W-1:0] bg_q, texel;
  logic [SX_W-1:0] pend_x_q, act_x_q, sx;
  logic [SY_W-1:0] pend_y_q, act_y_q, sy;
  logic [15:0] frame_cnt_q;
  logic [TE-1:0] sub_x_q, sub_y_q;
  logic [1:0] act_q, hs_q, vs_q;
  logic [TILE_IDX_W-1:0] tile_idx;
  logic [3:0] region;
  logic [1:0] reg_idx;
  logic acc, wr, frame_start, unused_bits;
  assign region = bus.iomem_addr[23:20];
  assign reg_idx = bus.iomem_addr[3:2];
  assign acc = bus.iomem_valid && !ready_q;
  assign wr = acc && bus.iomem_wstrb[0];
  assign frame_start = pix_en && x_px == '0 && y_px == '0;
  // The frame-start pixel already belongs to the new frame, so it sees the scroll being latched
  assign sx = SX_W'(x_px) + (frame_start ? pend_x_q : act_x_q);
  assign sy = SY_W'(y_px) + (frame_start ? pend_y_q : act_y_q);
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN_BIT] = en_q;
    ctrl_rd[CTRL_BG_LSB +: COLOR_W] = bg_q;
  end
  assign reg_rd = reg_idx == REG_CTRL     ? ctrl_rd :
                  reg_idx == REG_SCROLL_X ? 32'(pend_x_q) :
                  reg_idx == REG_SCROLL_Y ? 32'(pend_y_q) : {15'd0, vblank_q, frame_cnt_q};
  assign rdata_d = (acc && region == RGN_REG && bus.iomem_wstrb == '0) ? reg_rd : '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      en_q <= 1'b0;
      bg_q <= '0;
      pend_x_q <= '0;
      pend_y_q <= '0;
      act_x_q <= '0;
      act_y_q <= '0;
      frame_cnt_q <= '0;
      vblank_q <= 1'b0;
      sub_x_q <= '0;
      sub_y_q <= '0;
      act_q <= '0;
      hs_q <= '1;
      vs_q <= '1;
    end else begin
      ready_q <= acc;
      rdata_q <= rdata_d;
      if (wr && region == RGN_REG && reg_idx == REG_CTRL) begin
        en_q <= bus.iomem_wdata[CTRL_EN_BIT];
        bg_q <= bus.iomem_wdata[CTRL_BG_LSB +: COLOR_W];
      end
      if (wr && region == RGN_REG && reg_idx == REG_SCROLL_X) pend_x_q <= bus.iomem_wdata[SX_W-1:0];
      if (wr && region == RGN_REG && reg_idx == REG_SCROLL_Y) pend_y_q <= bus.iomem_wdata[SY_W-1:0];
      if (frame_start) begin
        act_x_q <= pend_x_q;
        act_y_q <= pend_y_q;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      // vblank latches on vsync and clears at the next frame start
      if (pix_en) begin
        vblank_q <= !frame_start && (vblank_q || !vsync_in);
        sub_x_q <= sx[TILE_LOG2-1:SCALE_LOG2];
        sub_y_q <= sy[TILE_LOG2-1:SCALE_LOG2];
        act_q <= {act_q[0], active_in};
        hs_q <= {hs_q[0], hsync_in};
        vs_q <= {vs_q[0], vsync_in};
      end
    end
  tilemap_dp_ram #(.DEPTH(1 << TILE_AW), .WIDTH(TILE_IDX_W)) u_tile_ram (
    .clk(clk),
    .we_i(wr && region == RGN_TILE),
    .waddr_i(bus.iomem_addr[TILE_AW+1:2]),
    .wdata_i(bus.iomem_wdata[TILE_IDX_W-1:0]),
    .re_i(pix_en),
    .raddr_i({sy[SY_W-1:TILE_LOG2], sx[SX_W-1:TILE_LOG2]}),
    .rdata_o(tile_idx)
  );
  tilemap_dp_ram #(.DEPTH(1 << TEX_AW), .WIDTH(COLOR_W)) u_tex_ram (
    .clk(clk),
    .we_i(wr && region == RGN_TEX),
    .waddr_i(bus.iomem_addr[TEX_AW+1:2]),
    .wdata_i(bus.iomem_wdata[COLOR_W-1:0]),
    .re_i(pix_en),
    .raddr_i({tile_idx, sub_y_q, sub_x_q}),
    .rdata_o(texel)
  );
  assign vga_rgb = act_q[1] ? (en_q ? texel : bg_q) : '0;
  assign vga_hsync = hs_q[1];
  assign vga_vsync = vs_q[1];
  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign unused_bits = ^{bus.iomem_addr, bus.iomem_wdata, bus.iomem_wstrb};
endmodule

// File: tb/tb_tilemap_video_engine.sv
// tb_tilemap_video_engine: directed checks of bus, pixel pipeline, scroll, wrap, status and async reset
module tb_tilemap_video_engine;
  localparam logic [31:0] REG = 32'h0000_0000, TEX = 32'h0010_0000, TILE = 32'h0020_0000;
  logic clk = 1'b0, resetn = 1'b0;
  logic pix_en, active_in, hsync_in, vsync_in, vga_hsync, vga_vsync;
  logic [9:0] x_px, y_px;
  logic [2:0] vga_rgb;
  int errors = 0, checks = 0, fcount = 0;
  always #5 clk = ~clk;
  tilemap_video_engine_if bus();
  tilemap_video_engine dut (
    .clk(clk), .resetn(resetn), .bus(bus), .pix_en(pix_en), .x_px(x_px), .y_px(y_px),
    .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_rgb(vga_rgb)
  );
  task automatic bus_rw(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd, output logic [31:0] rd);
    int n;
    @(negedge clk);
    bus.iomem_valid = 1'b1; bus.iomem_addr = a; bus.iomem_wstrb = ws; bus.iomem_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.iomem_ready && n < 8);
    checks++;
    if (!bus.iomem_ready) begin errors++; $display("FAIL bus_ack addr=%h ready=0 want 1", a); end
    rd = bus.iomem_rdata;
    bus.iomem_valid = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus_rw(a, 4'h1, d, r);
  endtask
  task automatic pix(input int x, input int y, input logic act, input logic hs, input logic vs);
    @(negedge clk);
    x_px = 10'(x); y_px = 10'(y); active_in = act; hsync_in = hs; vsync_in = vs; pix_en = 1'b1;
    if (x == 0 && y == 0) fcount++;
    @(negedge clk);
    pix_en = 1'b0;
  endtask
  task automatic test_reset;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    checks += 5;
    if (vga_rgb !== 3'b000) begin errors++; $display("FAIL rst_rgb got %b want 000", vga_rgb); end
    if (vga_hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync got %b want 1", vga_hsync); end
    if (vga_vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync got %b want 1", vga_vsync); end
    if (bus.iomem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.iomem_ready); end
    if (bus.iomem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus.iomem_rdata); end
    resetn = 1'b1;
    fcount = 0;
    @(negedge clk);
    bus.iomem_valid = 1'b1; bus.iomem_addr = REG; bus.iomem_wstrb = 4'h0; bus.iomem_wdata = 32'h0;
    @(negedge clk);
    checks += 2;
    if (bus.iomem_ready !== 1'b1) begin errors++; $display("FAIL ready_pulse got %b want 1", bus.iomem_ready); end
    if (bus.iomem_rdata !== 32'h0) begin errors++; $display("FAIL ctrl_rst got %h want 0", bus.iomem_rdata); end
    bus.iomem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.iomem_ready !== 1'b0) begin errors++; $display("FAIL ready_single got %b want 0", bus.iomem_ready); end
    for (int i = 0; i < 4; i++) begin
      bus_rw(REG + 32'(i * 4), 4'h0, 32'h0, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reg%0d_rst got %h want 0", i, d); end
    end
  endtask
  task automatic test_tile_basic;
    wr(TILE, 5);
    for (int i = 0; i < 64; i++) wr(TEX + 32'((5 * 64 + i) * 4), 32'b101);
    wr(REG, 32'h1);
    pix(20, 0, 0, 1, 1);
    pix(0, 0, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'b000) begin errors++; $display("FAIL latency_blank got %b want 000", vga_rgb); end
    pix(7, 0, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'b101) begin errors++; $display("FAIL px_0_0 got %b want 101", vga_rgb); end
    pix(15, 15, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'b101) begin errors++; $display("FAIL px_7_0 got %b want 101", vga_rgb); end
    pix(100, 100, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'b101) begin errors++; $display("FAIL px_15_15 got %b want 101", vga_rgb); end
  endtask
  task automatic test_sync;
    pix(30, 0, 0, 0, 1);
    checks++;
    if (vga_hsync !== 1'b1) begin errors++; $display("FAIL hsync_d1 got %b want 1", vga_hsync); end
    pix(31, 0, 0, 1, 0);
    checks += 2;
    if (vga_hsync !== 1'b0) begin errors++; $display("FAIL hsync_d2 got %b want 0", vga_hsync); end
    if (vga_vsync !== 1'b1) begin errors++; $display("FAIL vsync_d1 got %b want 1", vga_vsync); end
    pix(32, 0, 0, 1, 1);
    checks += 3;
    if (vga_hsync !== 1'b1) begin errors++; $display("FAIL hsync_back got %b want 1", vga_hsync); end
    if (vga_vsync !== 1'b0) begin errors++; $display("FAIL vsync_d2 got %b want 0", vga_vsync); end
    if (vga_rgb !== 3'b000) begin errors++; $display("FAIL blank_rgb got %b want 000", vga_rgb); end
  endtask
  task automatic test_scroll;
    logic [31:0] d;
    wr(TILE, 7);
    for (int ty = 0; ty < 8; ty++)
      for (int tx = 0; tx < 8; tx++) wr(TEX + 32'((7 * 64 + ty * 8 + tx) * 4), 32'(tx));
    pix(0, 0, 1, 1, 1);
    pix(4, 0, 1, 1, 1);
    pix(100, 100, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'd2) begin errors++; $display("FAIL scroll0_x4 got %0d want 2", vga_rgb); end
    wr(REG + 4, 8);
    pix(4, 0, 1, 1, 1);
    pix(100, 100, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'd2) begin errors++; $display("FAIL scroll_pending got %0d want 2", vga_rgb); end
    pix(0, 0, 1, 1, 1);
    pix(4, 0, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'd4) begin errors++; $display("FAIL scroll8_x0 got %0d want 4", vga_rgb); end
    pix(100, 100, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'd6) begin errors++; $display("FAIL scroll8_x4 got %0d want 6", vga_rgb); end
    bus_rw(REG + 4, 4'h0, 32'h0, d);
    checks++;
    if (d !== 32'd8) begin errors++; $display("FAIL scroll_x_rd got %0d want 8", d); end
  endtask
  task automatic test_wrap;
    wr(TILE + 32'(63 * 4), 7);
    wr(REG + 4, 1023);
    pix(0, 0, 1, 1, 1);
    pix(1, 0, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'd7) begin errors++; $display("FAIL wrap_x0 got %0d want 7", vga_rgb); end
    pix(3, 0, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'd0) begin errors++; $display("FAIL wrap_x1 got %0d want 0", vga_rgb); end
    pix(100, 100, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'd1) begin errors++; $display("FAIL wrap_x3 got %0d want 1", vga_rgb); end
    wr(REG + 4, 0);
  endtask
  task automatic test_bg_status;
    logic [31:0] d;
    wr(REG, 32'h20);
    pix(5, 5, 1, 1, 1);
    pix(100, 100, 0, 1, 1);
    checks++;
    if (vga_rgb !== 3'b010) begin errors++; $display("FAIL bg_active got %b want 010", vga_rgb); end
    pix(101, 100, 0, 1, 1);
    checks++;
    if (vga_rgb !== 3'b000) begin errors++; $display("FAIL bg_blank got %b want 000", vga_rgb); end
    bus_rw(REG, 4'h2, 32'h1, d);
    bus_rw(REG, 4'h0, 32'h0, d);
    checks++;
    if (d !== 32'h20) begin errors++; $display("FAIL ctrl_wstrb got %h want 00000020", d); end
    bus_rw(REG + 12, 4'h0, 32'h0, d);
    checks++;
    if (d !== 32'(fcount)) begin errors++; $display("FAIL status_a got %h want %h", d, 32'(fcount)); end
    pix(40, 300, 0, 1, 0);
    bus_rw(REG + 12, 4'h0, 32'h0, d);
    checks++;
    if (d !== (32'h1_0000 | 32'(fcount))) begin errors++; $display("FAIL status_vblank got %h want %h", d, 32'h1_0000 | 32'(fcount)); end
    pix(0, 0, 1, 1, 1);
    bus_rw(REG + 12, 4'h0, 32'h0, d);
    bus_rw(REG + 12, 4'h0, 32'h0, d);
    checks++;
    if (d !== 32'(fcount)) begin errors++; $display("FAIL status_inc got %h want %h", d, 32'(fcount)); end
    wr(REG + 12, 32'hFFFF_FFFF);
    bus_rw(REG + 12, 4'h0, 32'h0, d);
    checks++;
    if (d !== 32'(fcount)) begin errors++; $display("FAIL status_ro got %h want %h", d, 32'(fcount)); end
    bus_rw(TILE, 4'h0, 32'h0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ram_read got %h want 0", d); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] d;
    wr(REG, 32'h1);
    wr(REG + 4, 8);
    pix(0, 0, 1, 1, 1);
    pix(4, 3, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'd4) begin errors++; $display("FAIL pre_rst_x0 got %0d want 4", vga_rgb); end
    pix(100, 100, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'd6) begin errors++; $display("FAIL pre_rst_x4 got %0d want 6", vga_rgb); end
    #2 resetn = 1'b0;
    #1;
    checks += 2;
    if (vga_rgb !== 3'b000) begin errors++; $display("FAIL async_rst_rgb got %b want 000", vga_rgb); end
    if (vga_hsync !== 1'b1) begin errors++; $display("FAIL async_rst_hsync got %b want 1", vga_hsync); end
    @(negedge clk);
    resetn = 1'b1;
    fcount = 0;
    bus_rw(REG + 4, 4'h0, 32'h0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_scroll got %h want 0", d); end
    bus_rw(REG + 12, 4'h0, 32'h0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_status got %h want 0", d); end
    wr(REG, 32'h1);
    checks++;
    if (vga_rgb !== 3'b000) begin errors++; $display("FAIL rst_idle_rgb got %b want 000", vga_rgb); end
    pix(6, 0, 1, 1, 1);
    pix(2, 0, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'd3) begin errors++; $display("FAIL recover_x6 got %0d want 3", vga_rgb); end
    pix(100, 100, 1, 1, 1);
    checks++;
    if (vga_rgb !== 3'd1) begin errors++; $display("FAIL recover_x2 got %0d want 1", vga_rgb); end
  endtask
  initial begin
    bus.iomem_valid = 1'b0; bus.iomem_addr = '0; bus.iomem_wstrb = '0; bus.iomem_wdata = '0;
    pix_en = 1'b0; x_px = '0; y_px = '0; active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    test_reset;
    test_tile_basic;
    test_sync;
    test_scroll;
    test_wrap;
    test_bg_status;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
